// File: rtl/serial_slice_adder_if.sv
// Operand request / result bundle for the serial slice adder.
// The master side drives the request and operands; the slave side returns
// status and the registered result.
interface serial_slice_adder_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_slice_adder.sv
// Multi-cycle wide adder: streams WIDTH-bit operands SLICE bits per cycle
// through a single carry-select slice, least significant slice first.
// {cout, sum} = a + b + cin once done pulses; ovf is the signed overflow.
module serial_slice_adder #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_slice_adder_if.slave  io
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t             state_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   sum_reg;
   logic [IDX_W-1:0]   idx_reg;
   logic               carry_reg;
   logic               cout_reg;
   logic               ovf_reg;
   logic               busy_reg;
   logic               done_reg;

   // Current slice of each operand, selected by the slice index.
   logic [31:0]        slice_base;
   logic [SLICE-1:0]   slice_a;
   logic [SLICE-1:0]   slice_b;

   assign slice_base = 32'(idx_reg) * 32'(SLICE);
   assign slice_a    = a_reg[slice_base +: SLICE];
   assign slice_b    = b_reg[slice_base +: SLICE];

   // Two speculative ripple chains: one assuming carry-in 0, one carry-in 1.
   logic [SLICE:0]     c0_chain;
   logic [SLICE:0]     c1_chain;
   logic [SLICE-1:0]   s0;
   logic [SLICE-1:0]   s1;

   assign c0_chain[0] = 1'b0;
   assign c1_chain[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < SLICE; gi++) begin : g_ripple
         assign s0[gi]          = slice_a[gi] ^ slice_b[gi] ^ c0_chain[gi];
         assign c0_chain[gi+1]  = (slice_a[gi] & slice_b[gi]) |
                                  (slice_a[gi] & c0_chain[gi]) |
                                  (slice_b[gi] & c0_chain[gi]);
         assign s1[gi]          = slice_a[gi] ^ slice_b[gi] ^ c1_chain[gi];
         assign c1_chain[gi+1]  = (slice_a[gi] & slice_b[gi]) |
                                  (slice_a[gi] & c1_chain[gi]) |
                                  (slice_b[gi] & c1_chain[gi]);
      end
   endgenerate

   // The registered carry picks the real sum, carry-out and MSB carry-in.
   logic [SLICE-1:0]   slice_sum;
   logic               slice_cout;
   logic               slice_cmsb;

   assign slice_sum  = carry_reg ? s1 : s0;
   assign slice_cout = carry_reg ? c1_chain[SLICE]   : c0_chain[SLICE];
   assign slice_cmsb = carry_reg ? c1_chain[SLICE-1] : c0_chain[SLICE-1];

   // Control FSM and datapath registers; all outputs come straight from flops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               done_reg <= 1'b0;
               if (io.start) begin
                  a_reg     <= io.a;
                  b_reg     <= io.b;
                  carry_reg <= io.cin;
                  idx_reg   <= '0;
                  sum_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= ST_RUN;
               end else begin
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sum_reg[slice_base +: SLICE] <= slice_sum;
               carry_reg <= slice_cout;
               idx_reg   <= idx_reg + IDX_W'(1);
               if (idx_reg == LAST_IDX) begin
                  cout_reg  <= slice_cout;
                  ovf_reg   <= slice_cmsb ^ slice_cout;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= ST_DONE;
               end
            end
            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign io.busy = busy_reg;
   assign io.done = done_reg;
   assign io.sum  = sum_reg;
   assign io.cout = cout_reg;
   assign io.ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_slice_adder.sv
// Bench for serial_slice_adder: expected results are queued when an add is
// launched and popped when done pulses.
module tb_serial_slice_adder;

   localparam int WIDTH  = 32;
   localparam int SLICE  = 8;
   localparam int NSLICE = WIDTH / SLICE;

   logic clk;
   logic rst_n;

   serial_slice_adder_if #(.WIDTH(WIDTH)) bus ();

   serial_slice_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Drive a request at the current negedge; returns at the negedge after acceptance.
   task automatic launch(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc);
      exp_t        e;
      logic [32:0] full;
      full   = {1'b0, ta} + {1'b0, tb_v} + {32'd0, tc};
      e.a    = ta;
      e.b    = tb_v;
      e.cin  = tc;
      e.sum  = full[31:0];
      e.cout = full[32];
      e.ovf  = (ta[31] == tb_v[31]) && (full[31] != ta[31]);
      exp_q.push_back(e);
      bus.start = 1'b1;
      bus.a     = ta;
      bus.b     = tb_v;
      bus.cin   = tc;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.cin   = 1'($urandom_range(0, 1));
      checks++;
      if (bus.sum !== 32'd0) begin
         errors++;
         $display("FAIL accept_clear: sum=%h required 00000000", bus.sum);
      end
   endtask

   // Wait (bounded) for done, check latency and pop/compare the result.
   task automatic wait_done(input string name, input int exp_lat);
      int   cnt;
      exp_t e;
      cnt = 0;
      while (bus.done !== 1'b1 && cnt < 20) begin
         checks++;
         if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: busy=%b required 1 (cycle %0d)", name, bus.busy, cnt);
         end
         @(negedge clk);
         cnt++;
      end
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: done=%b required 1", name, bus.done);
         return;
      end
      checks++;
      if (cnt != exp_lat) begin
         errors++;
         $display("FAIL %s_latency: cycles=%0d required %0d", name, cnt, exp_lat);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy_done: busy=%b required 0", name, bus.busy);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s_unexpected_done: no queued result", name);
         return;
      end
      e = exp_q.pop_front();
      checks++;
      if (bus.sum !== e.sum || bus.cout !== e.cout || bus.ovf !== e.ovf) begin
         errors++;
         $display("FAIL %s_result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                  name, bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
      end
      $display("txn %s: %h + %h + %b -> sum=%h cout=%b ovf=%b", name, e.a, e.b, e.cin,
               bus.sum, bus.cout, bus.ovf);
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 32'd0 ||
          bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
                  bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: done=%b busy=%b required 0 0", bus.done, bus.busy);
         end
      end
   endtask

   task automatic test_carry();
      launch(32'h0000_00FF, 32'h0000_0001, 1'b0);
      wait_done("slice_carry", NSLICE);
      launch(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      wait_done("full_ripple", NSLICE);
   endtask

   task automatic test_overflow();
      launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      wait_done("ovf_pos", NSLICE);
      launch(32'h8000_0000, 32'h8000_0000, 1'b0);
      wait_done("ovf_neg", NSLICE);
   endtask

   task automatic test_back_to_back();
      launch(32'h1234_5678, 32'h1111_1111, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.sum !== 32'h0000_0089) begin
         errors++;
         $display("FAIL partial_sum1: sum=%h required 00000089", bus.sum);
      end
      bus.start = 1'b1;
      bus.a     = 32'hDEAD_BEEF;
      bus.b     = 32'hCAFE_F00D;
      bus.cin   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.sum !== 32'h0000_6789) begin
         errors++;
         $display("FAIL partial_sum2: sum=%h required 00006789", bus.sum);
      end
      wait_done("ignore_start", NSLICE - 2);
      launch(32'h0000_000A, 32'h0000_0014, 1'b0);
      wait_done("back_to_back", NSLICE);
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: done=%b busy=%b required 0 0", bus.done, bus.busy);
      end
   endtask

   task automatic test_abort();
      launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 32'd0 ||
          bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: busy=%b done=%b sum=%h cout=%b ovf=%b required all 0",
                  bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
      end
      rst_n = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: done=%b required 0", bus.done);
         end
      end
      launch(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);
      wait_done("after_abort", NSLICE);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         launch($urandom, $urandom, 1'($urandom_range(0, 1)));
         wait_done("random", NSLICE);
      end
   endtask

   initial begin
      test_reset();
      test_carry();
      test_overflow();
      test_back_to_back();
      test_abort();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_results: queued=%0d required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_slice_adder.md
Name: serial_slice_adder

Overview:
- Multi-cycle wide adder that streams WIDTH-bit operands, SLICE bits per cycle, through one carry-select slice adder.
- Feeds the 8-bit carry-select adder stage: it supplies each byte and its registered carry-in, and collects each byte sum and carry-out.
- Sits between the operand register file and the result writeback.
- Trades latency for area: a 32-bit add uses one 8-bit carry-select slice over 4 cycles.

Parameters:
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE, WIDTH >= SLICE.
- SLICE, 8, bits added per cycle; NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request; operands are captured when start=1 and the block is not busy.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- busy  output  1  high while slices are being processed (RUN).
- done  output  1  one-cycle pulse when sum/cout/ovf are valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; slice index=0; carry register=0. This applies in any state and aborts any add in progress without a done pulse.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE or DONE, start=1 at an edge:
  - latch a, b into operand registers;
  - carry register <= cin; index <= 0; sum <= 0;
  - go to RUN.
- IDLE, start=0: stay in IDLE.
- DONE, start=0: go to IDLE.
- RUN, each edge, for slice i = index:
  - sum[i*SLICE +: SLICE] <= slice result;
  - carry register <= slice carry-out;
  - index <= index+1.
  - When index = NSLICE-1: cout <= slice carry-out; ovf <= carry into slice MSB XOR slice carry-out; go to DONE.
- Slice datapath is carry-select:
  - two SLICE-bit ripple sums computed with carry 0 and carry 1;
  - the registered carry selects sum and carry-out;
  - carry-out = c1 | (c0 ... formally: sel ? c_one : c_zero.
- Latency: start accepted at edge t gives done=1 in the cycle after edge t+NSLICE (t+4 for defaults); busy=1 after edges t+1 .. t+NSLICE-1.
- Throughput: back-to-back start during the DONE cycle is accepted. done still pulses that cycle, and sum/cout/ovf are then overwritten as the new add proceeds (sum cleared at acceptance).
- start while in RUN (busy=1) is ignored; operands are not re-sampled.
- Operands a/b/cin may change freely after acceptance without affecting the result.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned exact.
- sum, cout and ovf are registered outputs; no combinational path from inputs to outputs.
- Mid-operation sum bits of slices not yet processed read 0.

Test Plan:
1. Hold rst_n=0 two edges, then release -> busy=0, done=0, sum=0x00000000, cout=0, ovf=0; no done without start.
2. a=0x000000FF, b=0x00000001, cin=0, start at edge t -> busy high t+1..t+3; done at t+4; sum=0x00000100, cout=0, ovf=0 (carry crosses slice 0->1).
3. a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0 (carry ripples through all 4 slices).
4. a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1; then a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
5. Start add (0x12345678 + 0x11111111), pulse start with other operands at t+2 -> ignored, sum=0x23456789. Then start in the DONE cycle with 0x0000000A + 0x00000014 -> accepted, next done gives sum=0x0000001E.
6. Start 0xFFFFFFFF + 0x00000001, drive rst_n=0 at t+2 -> all outputs 0, state IDLE, no done pulse. A fresh start afterwards produces a correct result.
